filter_pass_sequencer: RTL and testbench

- Sequences multi-pass disparity filtering over one frame held in BRAM.
- Drives the external raster/column address generator (go/vertical in; addr and line/frame flags out) through alternating horizontal and vertical passes.
- Derives write-back enables and addresses aligned to the fixed-latency filter pipeline.
- Drains the pipeline between passes, because passes run in place and the next pass must read fully written data.

---
 rtl/filter_pass_sequencer.sv | 174 +++++++++++++++++
 tb/tb_filter_pass_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_pass_sequencer.sv
// Sequences alternating horizontal/vertical in-place filter passes over one frame,
// driving the address generator and aligning write-back to the filter pipeline.
module filter_pass_sequencer #(
    parameter int unsigned WIDTH        = 120,
    parameter int unsigned HEIGHT       = 240,
    parameter int unsigned ADDR_W       = $clog2(WIDTH * HEIGHT),
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned PIPE_LAT     = 4,
    parameter int unsigned MAX_PASSES_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [MAX_PASSES_W-1:0] num_passes,
    input  logic                    first_vertical,
    input  logic                    hold,
    output logic                    ac_go,
    output logic                    ac_vertical,
    input  logic [ADDR_W-1:0]       ac_addr,
    input  logic                    ac_line_first,
    input  logic                    ac_line_last,
    input  logic                    ac_frame_last,
    output logic                    rd_valid,
    output logic                    rd_line_first,
    output logic                    rd_line_last,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [MAX_PASSES_W-1:0] pass_idx,
    output logic                    busy,
    output logic                    done
);

    // Total read-to-write latency; DRAIN lasts exactly this many cycles.
    localparam int unsigned LAT     = RD_LAT + PIPE_LAT;
    localparam int unsigned DRAIN_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [MAX_PASSES_W-1:0] num_passes_q, num_passes_d;
    logic [MAX_PASSES_W-1:0] pass_idx_q, pass_idx_d;
    logic                    ac_vertical_q, ac_vertical_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DRAIN_W-1:0]      drain_cnt_q, drain_cnt_d;
    logic [LAT-1:0]          go_pipe_q, go_pipe_d;
    logic [ADDR_W-1:0]       addr_pipe_q [LAT];
    logic [ADDR_W-1:0]       addr_pipe_d [LAT];
    logic [RD_LAT-1:0]       lf_pipe_q, lf_pipe_d;
    logic [RD_LAT-1:0]       ll_pipe_q, ll_pipe_d;
    logic                    go_c;

    // Read issue is masked by hold only; the delay lines keep shifting regardless.
    assign go_c = (state_q == S_ISSUE) && !hold;

    // Next-state and pass bookkeeping.
    always_comb begin
        state_d       = state_q;
        num_passes_d  = num_passes_q;
        pass_idx_d    = pass_idx_q;
        ac_vertical_d = ac_vertical_q;
        drain_cnt_d   = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_passes != '0) begin
                        num_passes_d  = num_passes;
                        pass_idx_d    = '0;
                        ac_vertical_d = first_vertical;
                        state_d       = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                // Generator wraps to address 0 on this advance.
                if (go_c && ac_frame_last) begin
                    drain_cnt_d = DRAIN_W'(LAT);
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                if (drain_cnt_q == DRAIN_W'(1)) begin
                    if (pass_idx_q == num_passes_q - MAX_PASSES_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        pass_idx_d    = pass_idx_q + MAX_PASSES_W'(1);
                        ac_vertical_d = !ac_vertical_q;
                        state_d       = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Delay lines aligning read flags and write-back to the filter pipeline.
    always_comb begin
        go_pipe_d    = '0;
        lf_pipe_d    = '0;
        ll_pipe_d    = '0;
        go_pipe_d[0] = go_c;
        lf_pipe_d[0] = go_c && ac_line_first;
        ll_pipe_d[0] = go_c && ac_line_last;
        addr_pipe_d[0] = ac_addr;
        for (int i = 1; i < int'(LAT); i++) begin
            go_pipe_d[i]   = go_pipe_q[i-1];
            addr_pipe_d[i] = addr_pipe_q[i-1];
        end
        for (int i = 1; i < int'(RD_LAT); i++) begin
            lf_pipe_d[i] = lf_pipe_q[i-1];
            ll_pipe_d[i] = ll_pipe_q[i-1];
        end
    end

    // State and delay-line registers; reset discards in-flight writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            num_passes_q  <= '0;
            pass_idx_q    <= '0;
            ac_vertical_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            drain_cnt_q   <= '0;
            go_pipe_q     <= '0;
            lf_pipe_q     <= '0;
            ll_pipe_q     <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                addr_pipe_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            num_passes_q  <= num_passes_d;
            pass_idx_q    <= pass_idx_d;
            ac_vertical_q <= ac_vertical_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            drain_cnt_q   <= drain_cnt_d;
            go_pipe_q     <= go_pipe_d;
            lf_pipe_q     <= lf_pipe_d;
            ll_pipe_q     <= ll_pipe_d;
            for (int i = 0; i < int'(LAT); i++) begin
                addr_pipe_q[i] <= addr_pipe_d[i];
            end
        end
    end

    assign ac_go         = go_c;
    assign ac_vertical   = ac_vertical_q;
    assign rd_valid      = go_pipe_q[RD_LAT-1];
    assign rd_line_first = lf_pipe_q[RD_LAT-1];
    assign rd_line_last  = ll_pipe_q[RD_LAT-1];
    assign wr_en         = go_pipe_q[LAT-1];
    assign wr_addr       = addr_pipe_q[LAT-1];
    assign pass_idx      = pass_idx_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_filter_pass_sequencer.sv
// Bench for filter_pass_sequencer: a behavioural address generator plus a
// per-cycle schedule built from the pass/hold/drain rules.
module tb_filter_pass_sequencer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int N    = W * H;
    localparam int RDL  = 1;
    localparam int PL   = 2;
    localparam int L    = RDL + PL;
    localparam int AW   = 3;
    localparam int PW   = 4;
    localparam int MAXC = 256;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [PW-1:0] num_passes;
    logic          first_vertical;
    logic          hold;
    logic          ac_go;
    logic          ac_vertical;
    logic [AW-1:0] ac_addr;
    logic          ac_line_first;
    logic          ac_line_last;
    logic          ac_frame_last;
    logic          rd_valid;
    logic          rd_line_first;
    logic          rd_line_last;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] pass_idx;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    filter_pass_sequencer #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .RD_LAT(RDL), .PIPE_LAT(PL), .MAX_PASSES_W(PW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_passes(num_passes),
        .first_vertical(first_vertical), .hold(hold), .ac_go(ac_go),
        .ac_vertical(ac_vertical), .ac_addr(ac_addr), .ac_line_first(ac_line_first),
        .ac_line_last(ac_line_last), .ac_frame_last(ac_frame_last), .rd_valid(rd_valid),
        .rd_line_first(rd_line_first), .rd_line_last(rd_line_last), .wr_en(wr_en),
        .wr_addr(wr_addr), .pass_idx(pass_idx), .busy(busy), .done(done)
    );

    // Pixel k of a pass in scan order, horizontal (raster) or vertical (column).
    function automatic int pix_addr(input int k, input bit v);
        return v ? ((k % H) * W + k / H) : k;
    endfunction
    function automatic bit pix_lf(input int k, input bit v);
        return v ? (k % H == 0) : (k % W == 0);
    endfunction
    function automatic bit pix_ll(input int k, input bit v);
        return v ? (k % H == H - 1) : (k % W == W - 1);
    endfunction

    // External address generator stand-in (synchronous reset).
    int g_idx;
    always @(posedge clk) begin
        if (!reset_n) g_idx <= 0;
        else if (ac_go) g_idx <= (g_idx == N - 1) ? 0 : g_idx + 1;
    end
    assign ac_addr       = AW'(pix_addr(g_idx, ac_vertical));
    assign ac_line_first = pix_lf(g_idx, ac_vertical);
    assign ac_line_last  = pix_ll(g_idx, ac_vertical);
    assign ac_frame_last = (g_idx == N - 1);

    // Expected per-cycle schedule, cycle 0 = the start cycle.
    bit hold_pat [MAXC];
    bit e_go [MAXC], e_rv [MAXC], e_rlf [MAXC], e_rll [MAXC], e_wr [MAXC];
    bit e_busy [MAXC], e_done [MAXC], e_pv [MAXC], e_vert [MAXC];
    int e_wa [MAXC], e_pidx [MAXC];
    int done_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_holds();
        for (int i = 0; i < MAXC; i++) hold_pat[i] = 1'b0;
    endtask

    task automatic mark(input int t, input int p, input bit v);
        e_busy[t] = 1'b1; e_pv[t] = 1'b1; e_pidx[t] = p; e_vert[t] = v;
    endtask

    task automatic build(input int np, input bit fv);
        int t;
        bit v;
        for (int i = 0; i < MAXC; i++) begin
            e_go[i] = 0; e_rv[i] = 0; e_rlf[i] = 0; e_rll[i] = 0; e_wr[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_pv[i] = 0; e_vert[i] = 0;
            e_wa[i] = 0; e_pidx[i] = 0;
        end
        t = 1;
        if (np == 0) begin
            e_busy[1] = 1; e_done[1] = 1; done_t = 1;
            return;
        end
        for (int p = 0; p < np; p++) begin
            v = fv ^ ((p % 2) == 1);
            for (int k = 0; k < N; k++) begin
                while (hold_pat[t]) begin
                    mark(t, p, v); t++;
                end
                e_go[t]      = 1;
                e_rv[t+RDL]  = 1;
                e_rlf[t+RDL] = pix_lf(k, v);
                e_rll[t+RDL] = pix_ll(k, v);
                e_wr[t+L]    = 1;
                e_wa[t+L]    = pix_addr(k, v);
                mark(t, p, v); t++;
            end
            for (int d = 0; d < L; d++) begin
                mark(t, p, v); t++;
            end
        end
        mark(t, np - 1, fv ^ (((np - 1) % 2) == 1));
        e_done[t] = 1;
        done_t = t;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".ac_go"}, 32'(ac_go), 0);
        chk({tag, ".ac_vertical"}, 32'(ac_vertical), 0);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 0);
        chk({tag, ".rd_line_first"}, 32'(rd_line_first), 0);
        chk({tag, ".rd_line_last"}, 32'(rd_line_last), 0);
        chk({tag, ".wr_en"}, 32'(wr_en), 0);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 0);
        chk({tag, ".pass_idx"}, 32'(pass_idx), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
    endtask

    // One run from an idle DUT; entered and left just after a rising edge.
    // spur_at: -1 none, -2 random busy cycle. rst_at >= 0 asserts reset in that cycle.
    task automatic run_frame(input string tag, input int np, input bit fv,
                             input int spur_at_in, input int spur_np, input int rst_at);
        int spur_at;
        build(np, fv);
        spur_at = (spur_at_in == -2) ? int'($urandom_range(1, done_t)) : spur_at_in;
        for (int c = 0; c <= done_t + 2; c++) begin
            if (rst_at >= 0 && c == rst_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                check_all_zero({tag, ".rst"});
                @(posedge clk);
                @(posedge clk);
                #1 reset_n = 1'b1;
                return;
            end
            start          = (c == 0) || (c == spur_at);
            num_passes     = PW'((c == spur_at) ? spur_np : np);
            first_vertical = (c == spur_at) ? !fv : fv;
            hold           = hold_pat[c];
            @(negedge clk);
            chk({tag, ".ac_go"}, 32'(ac_go), 32'(e_go[c]));
            chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(e_rv[c]));
            chk({tag, ".rd_line_first"}, 32'(rd_line_first), 32'(e_rlf[c]));
            chk({tag, ".rd_line_last"}, 32'(rd_line_last), 32'(e_rll[c]));
            chk({tag, ".wr_en"}, 32'(wr_en), 32'(e_wr[c]));
            if (e_wr[c]) chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(e_wa[c]));
            chk({tag, ".busy"}, 32'(busy), 32'(e_busy[c]));
            chk({tag, ".done"}, 32'(done), 32'(e_done[c]));
            if (e_pv[c]) begin
                chk({tag, ".pass_idx"}, 32'(pass_idx), 32'(e_pidx[c]));
                chk({tag, ".ac_vertical"}, 32'(ac_vertical), 32'(e_vert[c]));
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            hold  = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; num_passes = '0; first_vertical = 1'b0; hold = 1'b0;
        clear_holds();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single horizontal pass.
        run_frame("single_h", 1, 1'b0, -1, 0, -1);
        // Two passes, horizontal then vertical.
        run_frame("two_pass", 2, 1'b0, -1, 0, -1);
        // Hold during issue and during drain.
        hold_pat[3] = 1; hold_pat[4] = 1; hold_pat[5] = 1;
        hold_pat[12] = 1; hold_pat[13] = 1;
        run_frame("hold", 1, 1'b0, -1, 0, -1);
        clear_holds();
        // Zero passes.
        run_frame("zero_pass", 0, 1'b0, -1, 0, -1);
        // Start while busy with a different count.
        run_frame("spur_start", 1, 1'b1, 5, 3, -1);
        // Reset mid-ISSUE, then a clean pass.
        run_frame("rst_issue", 2, 1'b1, -1, 0, 4);
        run_frame("after_rst1", 1, 1'b0, -1, 0, -1);
        // Reset mid-DRAIN, then a clean pass.
        run_frame("rst_drain", 1, 1'b1, -1, 0, 10);
        run_frame("after_rst2", 1, 1'b1, -1, 0, -1);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            int np;
            bit fv;
            clear_holds();
            for (int c = 1; c < 100; c++) hold_pat[c] = ($urandom_range(0, 3) == 0);
            np = int'($urandom_range(0, 4));
            fv = 1'($urandom_range(0, 1));
            run_frame("rand", np, fv, ($urandom_range(0, 1) == 1) ? -2 : -1,
                      int'($urandom_range(0, 5)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
